sdram_scanout: RTL and testbench
================================

SDRAM_SCANOUT -- requirements
Module: sdram_scanout

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACTIVE 640 visible pixels per line
  H_FP 16 horizontal front porch
  H_SYNC 96 horizontal sync width
  H_BP 48 horizontal back porch
  V_ACTIVE 480 visible lines
  V_FP 10 vertical front porch
  V_SYNC 2 vertical sync width
  V_BP 33 vertical back porch
REQ-002 Ports (name, direction, width, meaning), one per line:
  CLK in 1 pixel clock, same clock as the SDRAM read FIFO read side
  RESET in 1 synchronous, active-high reset
  ENABLE in 1 scanout enable (level)
  RD_DATA in 16 read FIFO q, RGB565, valid 1 cycle after RD
  RD_EMPTY in 1 read FIFO empty
  RD out 1 read FIFO pop request
  RD_LOAD out 1 read address reload and FIFO clear
  VGA_HS out 1 horizontal sync, active-low
  VGA_VS out 1 vertical sync, active-low
  VGA_DE out 1 data enable
  VGA_R/VGA_G/VGA_B out 8 each colour channel
  FRAME_START out 1 one-cycle pulse at the first active pixel
  UNDERFLOW out 1 sticky underflow flag
  CLR_UNDERFLOW in 1 clears UNDERFLOW
REQ-003 The clock is CLK. Reset is RESET, synchronous and active-high.

Function
REQ-004 Counters: hcnt SHALL count 0..H_TOTAL-1, where H_TOTAL is the sum of the four H parameters (800). vcnt SHALL count 0..V_TOTAL-1 (525) and SHALL increment when hcnt wraps. Both SHALL wrap to 0.
REQ-005 Counter width SHALL be $clog2 of the total. No arithmetic SHALL overflow at the maximum parameters of 2048x2048 totals.
REQ-006 active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
REQ-007 hsync SHALL be asserted while H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. vsync SHALL use the same rule on vcnt.
REQ-008 FSM states:
  IDLE: counters held at 0, RD_LOAD=1, RD=0.
  ALIGN: counters run, no fetch.
  RUN: fetch and display.
REQ-009 FSM transitions:
  IDLE->ALIGN on ENABLE=1. hcnt SHALL be loaded with 0 and vcnt with V_ACTIVE.
  ALIGN->RUN when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
  Any state->IDLE on the cycle after ENABLE=0. Any fetch in flight SHALL be discarded.
REQ-010 RD_LOAD SHALL pulse for exactly one cycle in RUN and in ALIGN entry at hcnt=0, vcnt=V_ACTIVE (start of vertical blank). It SHALL be held high in IDLE.
REQ-011 In RUN, RD = active && !RD_EMPTY. RD SHALL never be asserted while RD_EMPTY=1.
REQ-012 Underflow: RUN && active && RD_EMPTY SHALL set UNDERFLOW. The pixel SHALL output as black (0,0,0) with VGA_DE still 1.
REQ-013 CLR_UNDERFLOW SHALL clear UNDERFLOW. A simultaneous set SHALL win.
REQ-014 Pipeline: VGA_DE, VGA_HS, VGA_VS and FRAME_START SHALL be delayed 2 cycles from the counters. RGB SHALL be registered from RD_DATA in the cycle after RD, so all outputs stay aligned (latency 2).
REQ-015 Colour expansion SHALL replicate MSBs:
  R = {d[15:11], d[15:13]}
  G = {d[10:5], d[10:9]}
  B = {d[4:0], d[4:2]}
REQ-016 VGA_DE SHALL be 0 outside RUN. Sync pulses SHALL continue in ALIGN and RUN, and SHALL be inactive (1) in IDLE.
REQ-017 FRAME_START SHALL be asserted only in RUN, for hcnt=0, vcnt=0 (after the 2-cycle delay).

Reset
REQ-018 RESET SHALL force the following:
  state=IDLE, hcnt=vcnt=0
  RD=0, RD_LOAD=1
  VGA_HS=VGA_VS=1, VGA_DE=0, RGB=0
  FRAME_START=0, UNDERFLOW=0
  pipeline registers cleared
REQ-019 RESET asserted mid-frame SHALL take effect on the next CLK edge with no extra RD pulse.

Structure
REQ-020 The timing defaults and FSM state encoding SHALL live in a shared package, scanout_pkg.
REQ-021 The counter and sync generation SHALL be one sub-module, vga_timing_gen. FSM, fetch and pipeline SHALL be in the top level.

Verification
REQ-022 Reset with ENABLE=1 held -> RD_LOAD pulse at vcnt=480, hcnt=0. The first VGA_DE rises 2 cycles after vcnt wraps to 0. FRAME_START coincides with it.
REQ-023 FIFO model always non-empty, RUN for one frame -> exactly 640x480=307200 RD pulses. Data 16'hF800 -> R=FF, G=00, B=00.
REQ-024 RD_EMPTY forced 1 for 3 cycles during line 10 -> RD=0 on those cycles, 3 black pixels, UNDERFLOW=1 held. CLR_UNDERFLOW -> 0.
REQ-025 ENABLE dropped at hcnt=100, vcnt=200 -> the next cycle enters IDLE: RD=0, RD_LOAD=1, DE=0 within 2 cycles, syncs 1.
REQ-026 Sync check -> HS low for 96 cycles starting at hcnt=656 (output cycle 658). VS low for 2 lines starting at vcnt=490. Periods are 800 and 525x800.
REQ-027 RESET pulsed mid-line -> all outputs at reset values on the next edge, then normal restart via ALIGN.

Source files
------------

// File: rtl/scanout_pkg.sv
// Shared timing defaults, FSM encoding and pixel helpers for the SDRAM scanout.
package scanout_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // state     | meaning
  // ST_IDLE   | counters held at 0, FIFO address held in reload, no fetch
  // ST_ALIGN  | counters free-running from vertical blank, syncs out, no fetch
  // ST_RUN    | fetch from FIFO and drive pixels
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } scan_state_t;

  // One pipeline slot; hs/vs are stored as "asserted" (active-high) and
  // inverted only at the pins, so an all-zero slot is the idle/reset value.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic fetch;
  } pipe_t;

  localparam pipe_t PIPE_IDLE = '0;

  // RGB565 to RGB888 by replicating the MSBs of each channel into the LSBs.
  function automatic logic [23:0] expand_565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters with active-window and sync decode.
module vga_timing_gen import scanout_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_end
);

  // Decode constants carry one extra bit so a sync end equal to the total
  // (zero back porch) still fits without wrapping.
  localparam logic [HW:0]   H_ACT_X = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SS_X  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SE_X  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_X = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SS_X  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SE_X  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_LOAD  = VW'(V_ACTIVE);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [HW:0]   hcnt_x;
  logic [VW:0]   vcnt_x;

  // Next counter value: clear wins, load jumps to start of vertical blank.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (clear) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (load) begin
      hcnt_d = '0;
      vcnt_d = V_LOAD;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_x    = {1'b0, hcnt_q};
  assign vcnt_x    = {1'b0, vcnt_q};
  assign hcnt      = hcnt_q;
  assign vcnt      = vcnt_q;
  assign active    = (hcnt_x < H_ACT_X) && (vcnt_x < V_ACT_X);
  assign hsync     = (hcnt_x >= H_SS_X) && (hcnt_x < H_SE_X);
  assign vsync     = (vcnt_x >= V_SS_X) && (vcnt_x < V_SE_X);
  assign frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/sdram_scanout.sv
// VGA scanout from an SDRAM read FIFO: sequencing FSM, fetch and output pipeline.
module sdram_scanout import scanout_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] RD_DATA,
  input  logic        RD_EMPTY,
  output logic        RD,
  output logic        RD_LOAD,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_DE,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        FRAME_START,
  output logic        UNDERFLOW,
  input  logic        CLR_UNDERFLOW
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [VW-1:0] V_LOAD = VW'(V_ACTIVE);

  scan_state_t   state_q, state_d;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, hsync, vsync, frame_end;
  logic          tg_clear, tg_load;
  logic          rd, rd_load, uf_set, at_blank_start;
  pipe_t         pipe1_q, pipe1_d, pipe2_q, pipe2_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          uf_q, uf_d;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (CLK),
    .reset     (RESET),
    .clear     (tg_clear),
    .load      (tg_load),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_end (frame_end)
  );

  assign at_blank_start = (hcnt == '0) && (vcnt == V_LOAD);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: ALIGN waits out the blank so RUN always starts at pixel 0,0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ENABLE) state_d = ST_ALIGN;
      ST_ALIGN: begin
        if (!ENABLE)        state_d = ST_IDLE;
        else if (frame_end) state_d = ST_RUN;
      end
      ST_RUN:   if (!ENABLE) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: counter control, FIFO handshake and first pipeline slot.
  always_comb begin
    tg_clear = !ENABLE;
    tg_load  = 1'b0;
    rd_load  = 1'b0;
    rd       = 1'b0;
    uf_set   = 1'b0;
    pipe1_d  = PIPE_IDLE;
    case (state_q)
      ST_IDLE: begin
        rd_load = 1'b1;
        tg_load = ENABLE;
      end
      ST_ALIGN: begin
        rd_load    = at_blank_start;
        pipe1_d.hs = hsync;
        pipe1_d.vs = vsync;
      end
      ST_RUN: begin
        rd_load       = at_blank_start;
        // A pop during a reset cycle would lose a pixel the restart expects.
        rd            = active && !RD_EMPTY && !RESET;
        uf_set        = active && RD_EMPTY;
        pipe1_d.de    = active;
        pipe1_d.hs    = hsync;
        pipe1_d.vs    = vsync;
        pipe1_d.fs    = (hcnt == '0) && (vcnt == '0);
        pipe1_d.fetch = rd;
      end
      default: ;
    endcase
  end

  // Second stage: flush on IDLE so a pop issued before disable never shows.
  always_comb begin
    pipe2_d = (state_q == ST_IDLE) ? PIPE_IDLE : pipe1_q;
    rgb_d   = ((state_q != ST_IDLE) && pipe1_q.fetch) ? expand_565(RD_DATA) : '0;
    uf_d    = uf_set ? 1'b1 : (CLR_UNDERFLOW ? 1'b0 : uf_q);
  end

  // Pipeline, pixel and sticky underflow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe1_q <= PIPE_IDLE;
      pipe2_q <= PIPE_IDLE;
      rgb_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      pipe1_q <= pipe1_d;
      pipe2_q <= pipe2_d;
      rgb_q   <= rgb_d;
      uf_q    <= uf_d;
    end
  end

  assign RD          = rd;
  assign RD_LOAD     = rd_load;
  assign VGA_DE      = pipe2_q.de;
  assign VGA_HS      = ~pipe2_q.hs;
  assign VGA_VS      = ~pipe2_q.vs;
  assign FRAME_START = pipe2_q.fs;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign UNDERFLOW   = uf_q;

endmodule

// File: tb/tb_sdram_scanout.sv
// Directed bench for sdram_scanout on a reduced 16x9 raster.
// Raster: H 8/2/3/3 (total 16, HS at h10..12), V 4/1/2/2 (total 9, VS at v5..6).
// Edge En is the n-th rising clock edge, E0 being the reset edge; all checks
// are taken 1 time unit after the named edge.
module tb_sdram_scanout;

  logic        clk = 1'b0;
  logic        reset, enable, rd_empty, clr_uf;
  logic [15:0] rd_data;
  logic        rd, rd_load, vga_hs, vga_vs, vga_de, frame_start, underflow;
  logic [7:0]  vga_r, vga_g, vga_b;

  int ecnt = -1;
  int total = 0;
  int bad = 0;
  int rd_count = 0;
  int rd_base = 0;

  sdram_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .CLK           (clk),
    .RESET         (reset),
    .ENABLE        (enable),
    .RD_DATA       (rd_data),
    .RD_EMPTY      (rd_empty),
    .RD            (rd),
    .RD_LOAD       (rd_load),
    .VGA_HS        (vga_hs),
    .VGA_VS        (vga_vs),
    .VGA_DE        (vga_de),
    .VGA_R         (vga_r),
    .VGA_G         (vga_g),
    .VGA_B         (vga_b),
    .FRAME_START   (frame_start),
    .UNDERFLOW     (underflow),
    .CLR_UNDERFLOW (clr_uf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd === 1'b1) rd_count <= rd_count + 1;

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic goto_edge(input int n);
    while (ecnt < n) tick();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_rd"}, rd, 1'b0);
    chk1({tag, "_rd_load"}, rd_load, 1'b1);
    chk1({tag, "_hs"}, vga_hs, 1'b1);
    chk1({tag, "_vs"}, vga_vs, 1'b1);
    chk1({tag, "_de"}, vga_de, 1'b0);
    chk24({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 24'h000000);
    chk1({tag, "_fs"}, frame_start, 1'b0);
    chk1({tag, "_uf"}, underflow, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    rd_empty = 1'b0;
    clr_uf   = 1'b0;
    rd_data  = 16'hF800;

    // Reset with ENABLE held high.
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;

    // E1: ALIGN entry at h0 v4 pulses RD_LOAD for one cycle.
    goto_edge(1);  chk1("align_load_on", rd_load, 1'b1);
    goto_edge(2);  chk1("align_load_off", rd_load, 1'b0);
    // Syncs run in ALIGN: HS for h10..12, VS from v5.
    goto_edge(12); chk1("align_hs_pre", vga_hs, 1'b1);
    goto_edge(13); chk1("align_hs_first", vga_hs, 1'b0);
    goto_edge(15); chk1("align_hs_last", vga_hs, 1'b0);
    goto_edge(16); chk1("align_hs_post", vga_hs, 1'b1);
    goto_edge(18); chk1("align_vs_pre", vga_vs, 1'b1);
    goto_edge(19); chk1("align_vs_first", vga_vs, 1'b0);
    goto_edge(30); chk1("align_no_de", vga_de, 1'b0);
    chk1("align_no_rd", rd, 1'b0);

    // E81: RUN begins at h0 v0; pixel k appears after E(83+k).
    goto_edge(81); rd_base = rd_count;
    goto_edge(82); chk1("run_de_before", vga_de, 1'b0);
    goto_edge(83);
    chk1("first_de", vga_de, 1'b1);
    chk1("first_fs", frame_start, 1'b1);
    chk24("red_f800", {vga_r, vga_g, vga_b}, 24'hFF0000);
    goto_edge(84); chk1("fs_one_cycle", frame_start, 1'b0);
    goto_edge(90); chk1("de_last_px", vga_de, 1'b1);
    goto_edge(91); chk1("de_h8_off", vga_de, 1'b0);
    goto_edge(92); chk1("run_hs_pre", vga_hs, 1'b1);
    goto_edge(93); chk1("run_hs_first", vga_hs, 1'b0);
    goto_edge(95); chk1("run_hs_last", vga_hs, 1'b0);
    goto_edge(96); chk1("run_hs_post", vga_hs, 1'b1);

    // Colour expansion on pixels 17..19 of frame 1.
    goto_edge(99);  rd_data = 16'h07E0;
    goto_edge(100); chk24("green_07e0", {vga_r, vga_g, vga_b}, 24'h00FF00);
    rd_data = 16'h001F;
    goto_edge(101); chk24("blue_001f", {vga_r, vga_g, vga_b}, 24'h0000FF);
    rd_data = 16'h8410;
    goto_edge(102); chk24("mid_8410", {vga_r, vga_g, vga_b}, 24'h848284);
    rd_data = 16'hF800;

    // RD_LOAD pulse in RUN at h0 v4.
    goto_edge(144); chk1("run_load_pre", rd_load, 1'b0);
    goto_edge(145); chk1("run_load_on", rd_load, 1'b1);
    goto_edge(146); chk1("run_load_off", rd_load, 1'b0);

    // VS low for lines 5 and 6.
    goto_edge(162); chk1("run_vs_pre", vga_vs, 1'b1);
    goto_edge(163); chk1("run_vs_first", vga_vs, 1'b0);
    goto_edge(194); chk1("run_vs_last", vga_vs, 1'b0);
    goto_edge(195); chk1("run_vs_post", vga_vs, 1'b1);

    // One full frame of non-empty FIFO gives 8x4 pops; frame 2 starts at E225.
    goto_edge(225);
    chk_int("frame_rd_count", rd_count - rd_base, 32);
    chk1("no_uf_frame1", underflow, 1'b0);
    goto_edge(227); chk1("frame2_fs", frame_start, 1'b1);

    // Underflow on line 2 of frame 2: empty for pixels 34..36.
    goto_edge(258); chk1("rd_nonempty", rd, 1'b1);
    goto_edge(259); rd_empty = 1'b1; #1;
    chk1("rd_blocked_empty", rd, 1'b0);
    chk1("uf_before_set", underflow, 1'b0);
    goto_edge(260);
    chk1("uf_set", underflow, 1'b1);
    chk1("rd_blocked_empty2", rd, 1'b0);
    chk24("px33_ok", {vga_r, vga_g, vga_b}, 24'hFF0000);
    goto_edge(261);
    chk24("px34_black", {vga_r, vga_g, vga_b}, 24'h000000);
    chk1("px34_de", vga_de, 1'b1);
    goto_edge(262); rd_empty = 1'b0;
    chk24("px35_black", {vga_r, vga_g, vga_b}, 24'h000000);
    goto_edge(263);
    chk24("px36_black", {vga_r, vga_g, vga_b}, 24'h000000);
    chk1("px36_de", vga_de, 1'b1);
    goto_edge(264); chk24("px37_ok", {vga_r, vga_g, vga_b}, 24'hFF0000);
    goto_edge(270); chk1("uf_sticky", underflow, 1'b1);
    clr_uf = 1'b1;
    goto_edge(271); chk1("uf_cleared", underflow, 1'b0);
    clr_uf = 1'b0;

    // Set and clear in the same cycle: set wins.
    goto_edge(273); rd_empty = 1'b1; clr_uf = 1'b1;
    goto_edge(274); chk1("uf_set_wins", underflow, 1'b1);
    rd_empty = 1'b0;
    goto_edge(275); chk1("uf_cleared2", underflow, 1'b0);
    clr_uf = 1'b0;

    // Disable at h5 v1 of frame 3 (frame 3 starts at E369).
    goto_edge(390); enable = 1'b0;
    goto_edge(391);
    chk1("dis_rd", rd, 1'b0);
    chk1("dis_rd_load", rd_load, 1'b1);
    goto_edge(392);
    chk1("dis_de", vga_de, 1'b0);
    chk1("dis_hs", vga_hs, 1'b1);
    chk1("dis_vs", vga_vs, 1'b1);
    chk24("dis_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
    goto_edge(395);
    chk1("idle_rd_load", rd_load, 1'b1);
    chk1("idle_de", vga_de, 1'b0);
    enable = 1'b1;

    // Re-enable: ALIGN at E396, RUN at E476.
    goto_edge(396); chk1("reen_load_on", rd_load, 1'b1);
    goto_edge(397); chk1("reen_load_off", rd_load, 1'b0);
    goto_edge(477); chk1("reen_de_pre", vga_de, 1'b0);
    goto_edge(478);
    chk1("reen_de", vga_de, 1'b1);
    chk1("reen_fs", frame_start, 1'b1);

    // Mid-line reset while UNDERFLOW is set.
    rd_empty = 1'b1;
    goto_edge(479); chk1("pre_reset_uf", underflow, 1'b1);
    reset = 1'b1; rd_empty = 1'b0; #1;
    chk1("reset_cycle_no_rd", rd, 1'b0);
    goto_edge(480);
    chk_reset_outputs("midreset");
    reset = 1'b0;
    goto_edge(481); chk1("restart_load_on", rd_load, 1'b1);
    goto_edge(482);
    chk1("restart_load_off", rd_load, 1'b0);
    chk1("restart_no_de", vga_de, 1'b0);
    goto_edge(563);
    chk1("restart_de", vga_de, 1'b1);
    chk1("restart_fs", frame_start, 1'b1);
    chk24("restart_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
